decode_cycle: RTL and testbench

Decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes its IF/ID outputs (InstrD, PCD, PCPlus4D). It decodes the instruction, reads the 32×32 register file (written back from the WB stage with same-cycle bypass) and generates the immediate. All results are registered into the ID/EX pipeline register, which the hazard unit can flush.

---
 rtl/decode_pkg.sv | 73 +++++++
 rtl/decode_cycle_register_file.sv | 38 +++
 rtl/decode_cycle.sv | 202 ++++++++++++++++++++
 tb/tb_decode_cycle.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU ops, immediate
// formats, result-source select and the registered control bundle.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        alu_src_a;
    logic        illegal;
    result_src_e result_src;
    alu_op_e     alu_control;
  } ctrl_t;

  // funct7[5] selects SUB only for register-register ops; shifts honour it in both forms.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                         input logic       funct7_5,
                                         input logic       is_rtype);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32 x XLEN register file: two async read ports with write-through bypass,
// one synchronous write port, synchronous clear of all entries.
module register_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [32];
  logic            wr_live;

  assign wr_live = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // A write landing this cycle is forwarded so decode sees the new value immediately.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = (wr_live && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != 5'd0) rdata2 = (wr_live && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate generation,
// and the flushable ID/EX pipeline register.
module decode_cycle #(
  parameter int XLEN = 32,
  parameter int PC_W = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [PC_W-1:0] PCD,
  input  logic [PC_W-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            ALUSrcAE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [PC_W-1:0] PCE,
  output logic [PC_W-1:0] PCPlus4E
);

  import decode_pkg::*;

  logic [6:0]             opcode;
  ctrl_t                  ctrl_p0;
  imm_src_e               imm_src_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [XLEN-1:0]        rd1_p0;
  logic [XLEN-1:0]        rd2_p0;

  ctrl_t                  ctrl_p1;
  logic [2:0]             funct3_p1;
  logic [4:0]             rs1_p1;
  logic [4:0]             rs2_p1;
  logic [4:0]             rd_p1;
  logic [XLEN-1:0]        rd1_p1;
  logic [XLEN-1:0]        rd2_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [PC_W-1:0]        pc_p1;
  logic [PC_W-1:0]        pc4_p1;

  function automatic logic signed [XLEN-1:0] sext_imm(input logic [31:0] instr,
                                                      input imm_src_e    src);
    logic signed [11:0]     i12;
    logic signed [11:0]     s12;
    logic signed [12:0]     b13;
    logic signed [20:0]     j21;
    logic signed [31:0]     u32;
    logic signed [XLEN-1:0] res;
    i12 = instr[31:20];
    s12 = {instr[31:25], instr[11:7]};
    b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    u32 = {instr[31:12], 12'b0};
    case (src)
      IMM_S:   res = XLEN'(s12);
      IMM_B:   res = XLEN'(b13);
      IMM_J:   res = XLEN'(j21);
      IMM_U:   res = XLEN'(u32);
      default: res = XLEN'(i12);
    endcase
    return res;
  endfunction

  assign opcode = InstrD[6:0];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  register_file #(.XLEN(XLEN)) u_register_file (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (InstrD[19:15]),
    .raddr2 (InstrD[24:20]),
    .rdata1 (rd1_p0),
    .rdata2 (rd2_p0)
  );

  // Stage p0: decode
  always_comb begin
    ctrl_p0    = '0;
    imm_src_p0 = IMM_I;
    case (opcode)
      OP_R: begin
        ctrl_p0.reg_write   = 1'b1;
        ctrl_p0.alu_control = alu_decode(InstrD[14:12], InstrD[30], 1'b1);
      end
      OP_I: begin
        ctrl_p0.reg_write   = 1'b1;
        ctrl_p0.alu_src     = 1'b1;
        ctrl_p0.alu_control = alu_decode(InstrD[14:12], InstrD[30], 1'b0);
      end
      OP_LOAD: begin
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.alu_src    = 1'b1;
        ctrl_p0.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        imm_src_p0        = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_p0.branch      = 1'b1;
        ctrl_p0.alu_control = ALU_SUB;
        imm_src_p0          = IMM_B;
      end
      OP_JAL: begin
        ctrl_p0.jump       = 1'b1;
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.result_src = RES_PC4;
        imm_src_p0         = IMM_J;
      end
      OP_JALR: begin
        ctrl_p0.jump       = 1'b1;
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.alu_src    = 1'b1;
        ctrl_p0.result_src = RES_PC4;
      end
      OP_LUI: begin
        ctrl_p0.reg_write   = 1'b1;
        ctrl_p0.alu_src     = 1'b1;
        ctrl_p0.alu_control = ALU_PASSB;
        imm_src_p0          = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_src_a = 1'b1;
        imm_src_p0        = IMM_U;
      end
      default: ctrl_p0.illegal = 1'b1;
    endcase
  end

  assign imm_p0 = sext_imm(InstrD, imm_src_p0);

  // Stage p1: ID/EX register; a flush is a full bubble, operands included
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ctrl_p1   <= '0;
      funct3_p1 <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
      pc4_p1    <= '0;
    end else begin
      ctrl_p1   <= ctrl_p0;
      funct3_p1 <= InstrD[14:12];
      rs1_p1    <= InstrD[19:15];
      rs2_p1    <= InstrD[24:20];
      rd_p1     <= InstrD[11:7];
      rd1_p1    <= rd1_p0;
      rd2_p1    <= rd2_p0;
      imm_p1    <= imm_p0;
      pc_p1     <= PCD;
      pc4_p1    <= PCPlus4D;
    end
  end

  assign RegWriteE   = ctrl_p1.reg_write;
  assign MemWriteE   = ctrl_p1.mem_write;
  assign JumpE       = ctrl_p1.jump;
  assign BranchE     = ctrl_p1.branch;
  assign ALUSrcE     = ctrl_p1.alu_src;
  assign ALUSrcAE    = ctrl_p1.alu_src_a;
  assign IllegalE    = ctrl_p1.illegal;
  assign ResultSrcE  = ctrl_p1.result_src;
  assign ALUControlE = ctrl_p1.alu_control;
  assign Funct3E     = funct3_p1;
  assign Rs1E        = rs1_p1;
  assign Rs2E        = rs2_p1;
  assign RdE         = rd_p1;
  assign RD1E        = rd1_p1;
  assign RD2E        = rd2_p1;
  assign ImmExtE     = imm_p1;
  assign PCE         = pc_p1;
  assign PCPlus4E    = pc4_p1;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: each applied instruction pushes its
// expected ID/EX contents, popped and compared one cycle later.
module tb_decode_cycle;

  localparam int XLEN = 32;
  localparam int PC_W = 13;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     InstrD = '0;
  logic [PC_W-1:0] PCD = '0;
  logic [PC_W-1:0] PCPlus4D = '0;
  logic            FlushE = 1'b0;
  logic            RegWriteW = 1'b0;
  logic [4:0]      RdW = '0;
  logic [XLEN-1:0] ResultW = '0;
  logic [4:0]      Rs1D, Rs2D;
  logic            RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, IllegalE;
  logic [1:0]      ResultSrcE;
  logic [3:0]      ALUControlE;
  logic [2:0]      Funct3E;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE;
  logic [PC_W-1:0] PCE, PCPlus4E;

  always #5 clk = ~clk;

  decode_cycle #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  typedef struct packed {
    logic        rw, mw, jump, branch, as, asa, ill;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
    logic        chk_imm;
    logic [12:0] pc, pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [31:0] ADDI5 = 32'hFFF00293;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // c = {RegWrite, MemWrite, Jump, Branch, ALUSrc, ALUSrcA, Illegal}
  function automatic exp_t ex(input logic [6:0] c, input logic [1:0] rsrc, input logic [3:0] alu,
                              input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic ci, input logic [12:0] pc);
    exp_t e;
    {e.rw, e.mw, e.jump, e.branch, e.as, e.asa, e.ill} = c;
    e.rsrc = rsrc;  e.alu = alu;
    e.f3  = instr[14:12];
    e.rs1 = instr[19:15];
    e.rs2 = instr[24:20];
    e.rd  = instr[11:7];
    e.rd1 = rd1;  e.rd2 = rd2;  e.imm = imm;  e.chk_imm = ci;
    e.pc  = pc;   e.pc4 = pc + 13'd4;
    return e;
  endfunction

  task automatic apply(input logic r, input logic fl, input logic wen, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] instr, input logic [12:0] pc,
                       input exp_t e);
    exp_t g;
    @(negedge clk);
    rst = r;  FlushE = fl;  RegWriteW = wen;  RdW = rd;  ResultW = res;
    InstrD = instr;  PCD = pc;  PCPlus4D = pc + 13'd4;
    exp_q.push_back(e);
    #1;
    check("Rs1D", 32'(Rs1D), 32'(instr[19:15]));
    check("Rs2D", 32'(Rs2D), 32'(instr[24:20]));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = exp_q.pop_front();
      check("RegWriteE",   32'(RegWriteE),   32'(g.rw));
      check("MemWriteE",   32'(MemWriteE),   32'(g.mw));
      check("JumpE",       32'(JumpE),       32'(g.jump));
      check("BranchE",     32'(BranchE),     32'(g.branch));
      check("ALUSrcE",     32'(ALUSrcE),     32'(g.as));
      check("ALUSrcAE",    32'(ALUSrcAE),    32'(g.asa));
      check("IllegalE",    32'(IllegalE),    32'(g.ill));
      check("ResultSrcE",  32'(ResultSrcE),  32'(g.rsrc));
      check("ALUControlE", 32'(ALUControlE), 32'(g.alu));
      check("Funct3E",     32'(Funct3E),     32'(g.f3));
      check("Rs1E",        32'(Rs1E),        32'(g.rs1));
      check("Rs2E",        32'(Rs2E),        32'(g.rs2));
      check("RdE",         32'(RdE),         32'(g.rd));
      check("RD1E",        RD1E,             g.rd1);
      check("RD2E",        RD2E,             g.rd2);
      if (g.chk_imm) check("ImmExtE", ImmExtE, g.imm);
      check("PCE",         32'(PCE),         32'(g.pc));
      check("PCPlus4E",    32'(PCPlus4E),    32'(g.pc4));
    end
  endtask

  initial begin
    exp_t z;
    z = '0;
    z.chk_imm = 1'b1;
    // Reset with a valid instruction present, then reset overriding a WB write
    apply(1, 0, 0, 5'd0, 32'h0, ADDI5, 13'h010, z);
    apply(0, 0, 1, 5'd1, 32'h55, 32'h0, 13'h004, ex(7'b0000001, 2'd0, 4'd0, 32'h0, 0, 0, 0, 1, 13'h004));
    apply(1, 0, 1, 5'd2, 32'h77, ADDI5, 13'h008, z);
    apply(0, 0, 0, 5'd0, 0, 32'h002081B3, 13'h00C, ex(7'b1000000, 0, 0, 32'h002081B3, 0, 0, 0, 0, 13'h00C));
    // addi x5,x0,-1
    apply(0, 0, 0, 5'd0, 0, ADDI5, 13'h010, ex(7'b1000100, 0, 0, ADDI5, 0, 0, 32'hFFFFFFFF, 1, 13'h010));
    // Same-cycle bypass, then discarded write to x0
    apply(0, 0, 1, 5'd3, 32'hDEADBEEF, 32'h003180B3, 13'h014,
          ex(7'b1000000, 0, 0, 32'h003180B3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 13'h014));
    apply(0, 0, 1, 5'd0, 32'h5, 32'h000000B3, 13'h018, ex(7'b1000000, 0, 0, 32'h000000B3, 0, 0, 0, 0, 13'h018));
    // beq x0,x0,-4
    apply(0, 0, 0, 5'd0, 0, 32'hFE000EE3, 13'h01C, ex(7'b0001000, 0, 1, 32'hFE000EE3, 0, 0, 32'hFFFFFFFC, 1, 13'h01C));
    // Flush with a concurrent write to x7, then read x7 back
    apply(0, 1, 1, 5'd7, 32'h12, ADDI5, 13'h020, z);
    apply(0, 0, 0, 5'd0, 0, 32'h000380B3, 13'h024, ex(7'b1000000, 0, 0, 32'h000380B3, 32'h12, 0, 0, 0, 13'h024));
    // Illegal opcode
    apply(0, 0, 0, 5'd0, 0, 32'h00000000, 13'h028, ex(7'b0000001, 0, 0, 32'h0, 0, 0, 0, 1, 13'h028));
    // Remaining formats and ALU selects
    apply(0, 0, 0, 5'd0, 0, 32'hFF80A203, 13'h02C, ex(7'b1000100, 1, 0, 32'hFF80A203, 0, 0, 32'hFFFFFFF8, 1, 13'h02C));
    apply(0, 0, 0, 5'd0, 0, 32'h00512423, 13'h030, ex(7'b0100100, 0, 0, 32'h00512423, 0, 0, 32'h8, 1, 13'h030));
    apply(0, 0, 0, 5'd0, 0, 32'hFF9FF0EF, 13'h034, ex(7'b1010000, 2, 0, 32'hFF9FF0EF, 0, 0, 32'hFFFFFFF8, 1, 13'h034));
    apply(0, 0, 0, 5'd0, 0, 32'h12345337, 13'h038,
          ex(7'b1000100, 0, 10, 32'h12345337, 0, 32'hDEADBEEF, 32'h12345000, 1, 13'h038));
    apply(0, 0, 0, 5'd0, 0, 32'hFFFFF397, 13'h03C, ex(7'b1000110, 0, 0, 32'hFFFFF397, 0, 0, 32'hFFFFF000, 1, 13'h03C));
    apply(0, 0, 0, 5'd0, 0, 32'h4041D493, 13'h040, ex(7'b1000100, 0, 7, 32'h4041D493, 32'hDEADBEEF, 0, 32'h404, 1, 13'h040));
    apply(0, 0, 0, 5'd0, 0, 32'h40000513, 13'h044, ex(7'b1000100, 0, 0, 32'h40000513, 0, 0, 32'h400, 1, 13'h044));
    apply(0, 0, 0, 5'd0, 0, 32'h403185B3, 13'h048,
          ex(7'b1000000, 0, 1, 32'h403185B3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 13'h048));
    apply(0, 0, 0, 5'd0, 0, 32'h004180E7, 13'h04C, ex(7'b1010100, 2, 0, 32'h004180E7, 32'hDEADBEEF, 0, 32'h4, 1, 13'h04C));
    apply(0, 0, 0, 5'd0, 0, 32'h0031C633, 13'h050,
          ex(7'b1000000, 0, 5, 32'h0031C633, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 13'h050));
    apply(0, 0, 0, 5'd0, 0, 32'h0011B693, 13'h054, ex(7'b1000100, 0, 4, 32'h0011B693, 32'hDEADBEEF, 0, 32'h1, 1, 13'h054));
    // Mid-operation reset clears x3 and x7 and beats a concurrent write
    apply(1, 0, 1, 5'd3, 32'hCAFEF00D, 32'h003180B3, 13'h058, z);
    apply(0, 0, 0, 5'd0, 0, 32'h003380B3, 13'h05C, ex(7'b1000000, 0, 0, 32'h003380B3, 0, 0, 0, 0, 13'h05C));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
